// File: rtl/dual_rail_pkg.sv
// Shared dual-rail definitions: pair codes and receiver FSM encoding.
// The transmitter side uses the same pair codes.
package dual_rail_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_RTZ  = 2'd2,
    ERR       = 2'd3
  } rx_state_e;

endpackage

// File: rtl/dual_rail_word_check.sv
// Combinational classifier for a dual-rail word: NULL / complete / illegal
// wavefront detection plus single-rail decode (true rail of each pair).
module dual_rail_word_check
  import dual_rail_pkg::*;
#(
  parameter int NBITS = 6
) (
  input  logic [2*NBITS-1:0] word,
  output logic               all_null,
  output logic               complete,
  output logic               illegal,
  output logic [NBITS-1:0]   bits
);

  logic [NBITS-1:0] is_null;
  logic [NBITS-1:0] is_data;
  logic [NBITS-1:0] is_ill;

  for (genvar k = 0; k < NBITS; k++) begin : g_pair
    logic [1:0] pair;
    assign pair       = word[2*k +: 2];
    assign is_null[k] = (pair == DR_NULL);
    assign is_data[k] = (pair == DR_ONE) || (pair == DR_ZERO);
    assign is_ill[k]  = (pair == DR_ILL);
    assign bits[k]    = pair[1];
  end

  assign all_null = &is_null;
  assign complete = &is_data;
  assign illegal  = |is_ill;

endmodule

// File: rtl/dual_rail_rx.sv
// Dual-rail receiver: synchronises the rails, waits for a stable complete
// wavefront, hands it to clocked logic over valid/ready and returns a 4-phase ack.
module dual_rail_rx
  import dual_rail_pkg::*;
#(
  parameter int NBITS       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*NBITS-1:0] dr_in,
  output logic               dr_ack,
  output logic [NBITS-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_illegal,
  output logic               err_timeout,
  input  logic               err_clr
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0][2*NBITS-1:0] sync_q;
  logic [2*NBITS-1:0]                  prev_q;
  logic [SYNC_STAGES:0]                vld_pipe;
  logic [2*NBITS-1:0]                  synced;

  logic             all_null, complete, illegal, stable, partial;
  logic [NBITS-1:0] dec_bits;
  logic             buf_free, capture, count_en, tmo_hit, set_ill;
  logic [CW-1:0]    cnt_q;
  rx_state_e        state_q, state_d;

  // vld_pipe marks which sync stages hold post-reset samples, so the
  // zeroed flops are never mistaken for a real NULL wavefront.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], dr_in};
      prev_q   <= sync_q[SYNC_STAGES-1];
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign stable = vld_pipe[SYNC_STAGES] && (synced == prev_q);

  dual_rail_word_check #(.NBITS(NBITS)) u_check (
    .word     (synced),
    .all_null (all_null),
    .complete (complete),
    .illegal  (illegal),
    .bits     (dec_bits)
  );

  assign partial  = !all_null && !complete && !illegal;
  assign buf_free = !out_valid || out_ready;
  assign capture  = (state_q == WAIT_DATA) && complete && stable && buf_free && !illegal;
  assign count_en = (state_q == WAIT_DATA) && (partial || (complete && !stable));
  assign tmo_hit  = count_en && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign set_ill  = illegal && (state_q != ERR);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (set_ill) begin
      state_d = ERR;
    end else begin
      case (state_q)
        IDLE:      if (all_null && vld_pipe[SYNC_STAGES-1]) state_d = WAIT_DATA;
        WAIT_DATA: if (tmo_hit) state_d = ERR;
                   else if (capture) state_d = WAIT_RTZ;
        WAIT_RTZ:  if (all_null) state_d = WAIT_DATA;
        ERR:       if (err_clr) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dr_ack = (state_q == WAIT_RTZ);
  end

  // Blocked-but-stable words hold the count: backpressure is not a stall.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (state_q != WAIT_DATA || all_null || illegal || capture)
      cnt_q <= '0;
    else if (count_en)
      cnt_q <= tmo_hit ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= dec_bits;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (set_ill)      err_illegal <= 1'b1;
      else if (err_clr) err_illegal <= 1'b0;
      if (tmo_hit)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_rail_rx.sv
// Bench for dual_rail_rx: directed handshake scenarios plus randomized
// sender traffic, all checked cycle by cycle against a behavioural model.
module tb_dual_rail_rx;

  localparam int NB  = 6;
  localparam int S   = 2;
  localparam int TMO = 255;
  localparam int W   = 2 * NB;

  logic          clk, rst, out_ready, err_clr;
  logic [W-1:0]  dr_in;
  logic          dr_ack, out_valid, err_illegal, err_timeout;
  logic [NB-1:0] out_data;

  int n_chk = 0;
  int n_err = 0;

  dual_rail_rx #(.NBITS(NB), .SYNC_STAGES(S), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .dr_in       (dr_in),
    .dr_ack      (dr_ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: phase 0 idle, 1 waiting for data, 2 waiting for NULL, 3 error.
  logic [W-1:0]  hist [0:S];
  int            nsamp, m_phase, m_cnt;
  bit            m_valid, m_ill, m_tmo;
  logic [NB-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] enc(input logic [NB-1:0] d);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < NB; k++) w[2*k +: 2] = d[k] ? 2'b10 : 2'b01;
    return w;
  endfunction

  task automatic step_model();
    logic [W-1:0]  sy, pv;
    logic [NB-1:0] dec;
    int nn, nok, nbad, p, nph, nc;
    bit an, cp, bad, part, stab, free, cap, cnting, hit;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_valid = 0; m_data = '0; m_ill = 0; m_tmo = 0;
      for (int i = 0; i <= S; i++) hist[i] = '0;
      nsamp = 0;
      return;
    end
    sy = hist[S-1];
    pv = hist[S];
    nn = 0; nok = 0; nbad = 0;
    for (int k = 0; k < NB; k++) begin
      p = int'((sy >> (2 * k)) & W'(3));
      if (p == 0) nn++;
      else if (p == 3) nbad++;
      else nok++;
      dec[k] = (p == 2);
    end
    an     = (nn == NB);
    cp     = (nok == NB);
    bad    = (nbad > 0);
    part   = !an && !cp && !bad;
    stab   = (nsamp > S) && (sy == pv);
    free   = !m_valid || out_ready;
    cap    = (m_phase == 1) && cp && stab && free;
    cnting = (m_phase == 1) && (part || (cp && !stab));
    hit    = cnting && (m_cnt + 1 >= TMO);
    nph = m_phase;
    if (m_phase != 3 && bad) nph = 3;
    else if (m_phase == 0 && an && nsamp >= S) nph = 1;
    else if (m_phase == 1 && hit) nph = 3;
    else if (m_phase == 1 && cap) nph = 2;
    else if (m_phase == 2 && an) nph = 1;
    else if (m_phase == 3 && err_clr) nph = 0;
    if (m_phase != 1 || an || bad || cap) nc = 0;
    else if (cnting) nc = hit ? 0 : m_cnt + 1;
    else nc = m_cnt;
    if (cap) begin
      m_data = dec;
      m_valid = 1;
    end else if (m_valid && out_ready) m_valid = 0;
    if (m_phase != 3 && bad) m_ill = 1;
    else if (err_clr) m_ill = 0;
    if (hit) m_tmo = 1;
    else if (err_clr) m_tmo = 0;
    m_phase = nph;
    m_cnt = nc;
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = dr_in;
    if (nsamp < 1000) nsamp++;
  endtask

  task automatic tick();
    step_model();
    @(posedge clk);
    #1;
    chk("ack", dr_ack, (m_phase == 2));
    chk("valid", out_valid, m_valid);
    chk("data", out_data, m_data);
    chk("err_ill", err_illegal, m_ill);
    chk("err_tmo", err_timeout, m_tmo);
  endtask

  task automatic tick_r();
    out_ready = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic send(input logic [NB-1:0] d);
    logic [W-1:0] w, m;
    int b;
    w = enc(d);
    if ($urandom_range(0, 1) == 1) begin
      m = '0;
      for (int k = 0; k < NB; k++) if ($urandom_range(0, 1) == 1) m[2*k +: 2] = 2'b11;
      dr_in = w & m;
      repeat ($urandom_range(1, 3)) tick_r();
    end
    dr_in = w;
    b = 0;
    while (m_phase != 2 && b < 300) begin tick_r(); b++; end
    if (m_phase != 2) chk("hs_ack_rise_wait", dr_ack, 1);
    dr_in = '0;
    b = 0;
    while (m_phase == 2 && b < 300) begin tick_r(); b++; end
    if (m_phase == 2) chk("hs_ack_fall_wait", dr_ack, 0);
  endtask

  task automatic inject_illegal();
    logic [W-1:0] w;
    int k;
    k = $urandom_range(0, NB - 1);
    w = enc(6'($urandom_range(0, 63)));
    w[2*k +: 2] = 2'b11;
    dr_in = w;
    repeat (3) tick_r();
    dr_in = '0;
    repeat (3) tick_r();
    err_clr = 1;
    tick_r();
    err_clr = 0;
  endtask

  initial begin
    rst = 1; dr_in = '0; out_ready = 1; err_clr = 0;
    tick(); tick();
    chk("rst_ack", dr_ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ill", err_illegal, 0);
    chk("rst_tmo", err_timeout, 0);
    rst = 0;
    repeat (3) tick();

    dr_in = 12'h666;
    repeat (3) tick();
    chk("lat_early", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 6'b010101);
    chk("lat_ack", dr_ack, 1);
    dr_in = 12'h000;
    repeat (2) tick();
    chk("rtz_hold", dr_ack, 1);
    tick();
    chk("rtz_fall", dr_ack, 0);
    dr_in = 12'h999;
    repeat (4) tick();
    chk("d999_data", out_data, 6'b101010);
    chk("d999_valid", out_valid, 1);
    dr_in = 12'h000;
    repeat (3) tick();

    out_ready = 0;
    dr_in = 12'h555;
    repeat (4) tick();
    chk("bp_first", out_data, 6'h00);
    chk("bp_first_v", out_valid, 1);
    dr_in = 12'h000;
    repeat (3) tick();
    dr_in = 12'h666;
    repeat (8) tick();
    chk("bp_stall_ack", dr_ack, 0);
    chk("bp_hold", out_data, 6'h00);
    out_ready = 1;
    tick();
    chk("bp_swap_v", out_valid, 1);
    chk("bp_swap_d", out_data, 6'h15);
    chk("bp_swap_ack", dr_ack, 1);
    dr_in = 12'h000;
    repeat (3) tick();

    dr_in = 12'h003;
    repeat (3) tick();
    chk("ill_flag", err_illegal, 1);
    chk("ill_ack", dr_ack, 0);
    dr_in = 12'h000;
    repeat (3) tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("ill_clr", err_illegal, 0);
    dr_in = 12'h555;
    repeat (4) tick();
    chk("ill_rec_v", out_valid, 1);
    chk("ill_rec_d", out_data, 6'h00);
    dr_in = 12'h000;
    repeat (3) tick();

    dr_in = 12'h001;
    repeat (256) tick();
    chk("tmo_before", err_timeout, 0);
    tick();
    chk("tmo_flag", err_timeout, 1);
    repeat (43) tick();
    chk("tmo_novalid", out_valid, 0);
    chk("tmo_ack", dr_ack, 0);
    dr_in = 12'h000;
    repeat (3) tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("tmo_clr", err_timeout, 0);

    out_ready = 0;
    dr_in = 12'h666;
    repeat (4) tick();
    chk("mid_ack", dr_ack, 1);
    chk("mid_valid", out_valid, 1);
    rst = 1;
    tick();
    chk("mid_rst_ack", dr_ack, 0);
    chk("mid_rst_valid", out_valid, 0);
    rst = 0;
    repeat (10) tick();
    chk("mid_nocap", out_valid, 0);
    dr_in = 12'h000;
    repeat (3) tick();
    dr_in = 12'h666;
    repeat (4) tick();
    chk("mid_cap_v", out_valid, 1);
    chk("mid_cap_d", out_data, 6'h15);
    out_ready = 1;
    dr_in = 12'h000;
    repeat (4) tick();

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) inject_illegal();
      else send(6'($urandom_range(0, 63)));
    end
    out_ready = 1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
